avmm_sram_bridge: RTL and testbench
===================================

# avmm_sram_bridge

Parametrised Avalon-MM slave to asynchronous SRAM controller, the successor to the fixed 32-to-16-bit SRAM controller. It splits each Avalon word into RATIO = AVS_DW/SRAM_DW SRAM beats and inserts a programmable number of wait cycles per beat. Unlike its predecessor, it has explicit waitrequest/readdatavalid handshaking, and it skips write beats whose byte lanes are all disabled. It sits between the system interconnect and the board SRAM pins. A separate top-level pad wrapper merges sram_writedata/sram_readdata onto the bidirectional bus.

## Interface
- AVS_DW, 32: Avalon data width; must be SRAM_DW, 2*SRAM_DW or 4*SRAM_DW.
- SRAM_DW, 16: SRAM data width; multiple of 8.
- SRAM_AW, 18: SRAM address width in SRAM words.
- WAIT_CYCLES, 0: extra cycles per beat, 0..15.
- AVS_AW, SRAM_AW+log2(SRAM_DW/8): derived byte-address width; not overridden.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  AVS_AW  byte address; bits below log2(AVS_DW/8) ignored.
- avs_byteenable  in  AVS_DW/8  write byte lanes; ignored for reads.
- avs_read  in  1  read request.
- avs_write  in  1  write request; wins if asserted together with avs_read.
- avs_writedata  in  AVS_DW  write data.
- avs_waitrequest  out  1  high while busy; request accepted on an edge where it is low.
- avs_readdata  out  AVS_DW  read data, held until the next read completes.
- avs_readdatavalid  out  1  one-cycle pulse marking valid avs_readdata.
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_writedata  out  SRAM_DW  write data to pads.
- sram_readdata  in  SRAM_DW  read data from pads.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low chip, output and write enables.
- sram_be_n  out  SRAM_DW/8  active-low byte lane enables (bit 0 = lowest byte).

## Operation
- FSM states: IDLE, ACCESS, TURN. avs_waitrequest = (state != IDLE), registered.
- Accept:
  - In IDLE with avs_read or avs_write high at an edge, latch the word address, op, byteenable and writedata.
  - Beat k (0..RATIO-1) carries avs bits [k*SRAM_DW +: SRAM_DW].
  - sram_addr = {avs_address[AVS_AW-1:log2(AVS_DW/8)], k} (little-endian beat order).
- Beat selection:
  - A read visits every beat, with sram_be_n all 0.
  - A write visits only beats whose byteenable slice is nonzero; sram_be_n = ~slice.
  - A write with no enabled beat stays in IDLE: accepted in one cycle, no SRAM activity.
- ACCESS:
  - Lasts 1+WAIT_CYCLES cycles with sram_ce_n=0, and sram_oe_n=0 (read) or sram_we_n=0 (write).
  - sram_addr, sram_be_n and sram_writedata are registered and stable for the whole beat.
  - Reads capture sram_readdata into beat slice k on the final ACCESS edge.
- TURN:
  - One cycle with ce_n/oe_n/we_n=1 between consecutive beats (write recovery, bus turnaround).
  - Not inserted after the last beat.
- Completion:
  - After the last beat the FSM returns to IDLE.
  - For a read, avs_readdatavalid pulses in that first IDLE cycle, with avs_readdata fully assembled.
  - A new request may be accepted in that same cycle.
- Reset values:
  - avs_waitrequest=0, avs_readdatavalid=0, avs_readdata=0.
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_be_n all 1, sram_addr=0, sram_writedata=0, state IDLE.

## Timing
- Request accepted at edge 0. Each beat takes 1+WAIT_CYCLES cycles, plus one TURN cycle between beats.
- Defaults (RATIO=2, WAIT_CYCLES=0), full write:
  - ACCESS cycle 1, TURN cycle 2, ACCESS cycle 3, IDLE cycle 4.
  - avs_waitrequest is high in cycles 1-3.
- Defaults, read: same cycle sequence; avs_readdatavalid high in cycle 4.
- General read latency, edge of acceptance to avs_readdatavalid: N*(1+WAIT_CYCLES)+(N-1)+1 cycles, N=RATIO.
- Write with one enabled beat: 1+WAIT_CYCLES busy cycles.
- Reset mid-operation:
  - Asynchronous return to reset values.
  - No avs_readdatavalid for the aborted read.
  - SRAM contents of the in-flight beat are undefined.
- avs_read/avs_write while avs_waitrequest=1 are ignored (the master holds them).

## Test plan
- Defaults; write 0x0 = 0xcccc0123, then read 0x0 -> SRAM words 0=0x0123 and 1=0xcccc; avs_readdata=0xcccc0123 with avs_readdatavalid exactly 4 cycles after acceptance.
- Write 0x20 = 0xdeadbeef, then write 0x20 with byteenable 4'b0011, data 0x0000ffff -> only one ACCESS (sram_addr=0x10, sram_be_n=2'b00); read returns 0xdeadffff.
- Write 0x10 with byteenable 4'b1000, data 0xff345678 over prior 0x12345678 -> single beat at sram_addr=0x9 with sram_be_n=2'b01; read with byteenable 4'b0011 returns 0xff345678.
- Write with byteenable 4'b0000 -> avs_waitrequest never rises, sram_ce_n stays 1, memory unchanged.
- AVS_DW=64, SRAM_DW=16, WAIT_CYCLES=2; write/read 0x8 = 0x0123456789abcdef -> four 3-cycle beats at sram_addr 4..7; read latency 16 cycles; data matches.
- Assert reset_n low during the second beat of a read -> outputs at reset values immediately, no avs_readdatavalid; a subsequent read of a written address returns correct data.

Source files
------------

// File: rtl/avmm_sram_bridge.sv
// avmm_sram_bridge
//   Avalon-MM slave to asynchronous SRAM controller. Each Avalon word is split
//   into RATIO = AVS_DW/SRAM_DW SRAM beats, little-endian (beat k carries
//   avs bits [k*SRAM_DW +: SRAM_DW] at SRAM word {word_addr, k}). Every beat
//   holds the SRAM strobes for 1+WAIT_CYCLES cycles. A one-cycle turnaround
//   separates consecutive beats. Write beats whose byte lanes are all
//   disabled are skipped. A write with no enabled lane completes in IDLE.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   avs_address           byte address (bits below the word offset ignored)
//   avs_byteenable        write byte lanes (ignored for reads)
//   avs_read/avs_write    requests; write wins when both are high
//   avs_writedata         write data
//   avs_waitrequest       high while a transfer is in flight
//   avs_readdata          assembled read word, held until the next read ends
//   avs_readdatavalid     one-cycle pulse with valid avs_readdata
//   sram_addr             SRAM word address
//   sram_writedata        write data towards the pad wrapper
//   sram_readdata         read data from the pad wrapper
//   sram_ce_n/oe_n/we_n   active-low chip/output/write enables
//   sram_be_n             active-low byte lane enables
module avmm_sram_bridge #(
  parameter int unsigned AVS_DW      = 32,
  parameter int unsigned SRAM_DW     = 16,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned AVS_AW      = SRAM_AW + $clog2(SRAM_DW / 8)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [AVS_AW-1:0]      avs_address,
  input  logic [AVS_DW/8-1:0]    avs_byteenable,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [AVS_DW-1:0]      avs_writedata,
  output logic                   avs_waitrequest,
  output logic [AVS_DW-1:0]      avs_readdata,
  output logic                   avs_readdatavalid,
  output logic [SRAM_AW-1:0]     sram_addr,
  output logic [SRAM_DW-1:0]     sram_writedata,
  input  logic [SRAM_DW-1:0]     sram_readdata,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic [SRAM_DW/8-1:0]   sram_be_n
);

  localparam int unsigned RATIO    = AVS_DW / SRAM_DW;
  localparam int unsigned BEAT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned AVS_BE   = AVS_DW / 8;
  localparam int unsigned SRAM_BE  = SRAM_DW / 8;
  localparam int unsigned SRAM_LSB = $clog2(SRAM_BE);

  typedef enum logic [1:0] {StIdle, StAccess, StTurn} state_e;

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 is_write_q, is_write_d;
  logic [RATIO-1:0]     mask_q, mask_d;
  logic [AVS_BE-1:0]    be_q, be_d;
  logic [AVS_DW-1:0]    wdata_q, wdata_d;
  logic [SRAM_AW-1:0]   base_q, base_d;
  logic [AVS_DW-1:0]    rbuf_q, rbuf_d;
  logic [AVS_DW-1:0]    rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 waitreq_q;
  logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0]   sram_wdata_q, sram_wdata_d;
  logic                 ce_n_q, ce_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic [SRAM_BE-1:0]   be_n_q, be_n_d;

  // Which beats a request visits: all of them for a read, only beats with at
  // least one enabled lane for a write.
  function automatic logic [RATIO-1:0] beat_mask(input logic wr,
                                                 input logic [AVS_BE-1:0] be);
    logic [RATIO-1:0] m;
    for (int k = 0; k < int'(RATIO); k++) begin
      m[k] = wr ? |be[k*SRAM_BE +: SRAM_BE] : 1'b1;
    end
    return m;
  endfunction

  // Lowest enabled beat at or above 'from'; MSB of the result is the hit flag.
  function automatic logic [BEAT_W:0] find_beat(input logic [RATIO-1:0] mask,
                                                input int from);
    logic              found;
    logic [BEAT_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int k = int'(RATIO) - 1; k >= 0; k--) begin
      if (k >= from && mask[k]) begin
        found = 1'b1;
        idx   = BEAT_W'(k);
      end
    end
    return {found, idx};
  endfunction

  logic [RATIO-1:0]   req_mask;
  logic [BEAT_W:0]    hit;
  logic [SRAM_AW-1:0] req_base;
  logic               start_beat;
  logic [BEAT_W-1:0]  start_idx;
  logic               start_wr;
  logic [SRAM_AW-1:0] start_base;
  logic [AVS_BE-1:0]  start_be;
  logic [AVS_DW-1:0]  start_wdata;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    is_write_d   = is_write_q;
    mask_d       = mask_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    base_d       = base_q;
    rbuf_d       = rbuf_q;
    rdata_d      = rdata_q;
    rvalid_d     = 1'b0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    be_n_d       = be_n_q;
    req_mask     = '0;
    hit          = '0;
    req_base     = '0;
    start_beat   = 1'b0;
    start_idx    = '0;
    start_wr     = 1'b0;
    start_base   = '0;
    start_be     = '0;
    start_wdata  = '0;

    unique case (state_q)
      StIdle: begin
        if (avs_write || avs_read) begin
          req_mask = beat_mask(avs_write, avs_byteenable);
          hit      = find_beat(req_mask, 0);
          // Word-aligned SRAM base: beat index is added on top.
          req_base = avs_address[AVS_AW-1:SRAM_LSB] & ~SRAM_AW'(RATIO - 1);
          is_write_d = avs_write;
          mask_d     = req_mask;
          be_d       = avs_byteenable;
          wdata_d    = avs_writedata;
          base_d     = req_base;
          if (hit[BEAT_W]) begin
            state_d     = StAccess;
            beat_d      = hit[BEAT_W-1:0];
            cnt_d       = '0;
            start_beat  = 1'b1;
            start_idx   = hit[BEAT_W-1:0];
            start_wr    = avs_write;
            start_base  = req_base;
            start_be    = avs_byteenable;
            start_wdata = avs_writedata;
          end
        end
      end

      StAccess: begin
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          if (!is_write_q) begin
            rbuf_d[int'(beat_q)*SRAM_DW +: SRAM_DW] = sram_readdata;
          end
          hit    = find_beat(mask_q, int'(beat_q) + 1);
          ce_n_d = 1'b1;
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          be_n_d = '1;
          if (hit[BEAT_W]) begin
            state_d = StTurn;
            beat_d  = hit[BEAT_W-1:0];
          end else begin
            state_d = StIdle;
            if (!is_write_q) begin
              // Publish the whole word at once so avs_readdata only ever
              // changes when a read completes.
              rvalid_d = 1'b1;
              rdata_d  = rbuf_d;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      StTurn: begin
        state_d     = StAccess;
        cnt_d       = '0;
        start_beat  = 1'b1;
        start_idx   = beat_q;
        start_wr    = is_write_q;
        start_base  = base_q;
        start_be    = be_q;
        start_wdata = wdata_q;
      end

      default: state_d = StIdle;
    endcase

    // SRAM pins for a beat are set up once on entry to ACCESS and held.
    if (start_beat) begin
      sram_addr_d  = start_base + SRAM_AW'(start_idx);
      sram_wdata_d = start_wdata[int'(start_idx)*SRAM_DW +: SRAM_DW];
      ce_n_d       = 1'b0;
      oe_n_d       = start_wr;
      we_n_d       = ~start_wr;
      be_n_d       = start_wr ? ~start_be[int'(start_idx)*SRAM_BE +: SRAM_BE] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      cnt_q        <= '0;
      is_write_q   <= 1'b0;
      mask_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      base_q       <= '0;
      rbuf_q       <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      waitreq_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= '1;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      mask_q       <= mask_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      base_q       <= base_d;
      rbuf_q       <= rbuf_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      waitreq_q    <= (state_d != StIdle);
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
    end
  end

  // Sub-SRAM-word byte offset bits carry no information for this bridge.
  if (SRAM_LSB > 0) begin : g_unused_addr
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^avs_address[SRAM_LSB-1:0];
  end

  assign avs_waitrequest   = waitreq_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign sram_addr         = sram_addr_q;
  assign sram_writedata    = sram_wdata_q;
  assign sram_ce_n         = ce_n_q;
  assign sram_oe_n         = oe_n_q;
  assign sram_we_n         = we_n_q;
  assign sram_be_n         = be_n_q;

endmodule

// File: tb/tb_avmm_sram_bridge.sv
// Directed bench for avmm_sram_bridge: a default 32/16 instance (a_*) and a
// 64/16 instance with two wait cycles (b_*), each backed by a small SRAM model.
module tb_avmm_sram_bridge;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic [18:0] a_address;
  logic [3:0]  a_be;
  logic        a_read, a_write;
  logic [31:0] a_wdata, a_rdata;
  logic        a_wait, a_rvalid;
  logic [17:0] a_sram_addr;
  logic [15:0] a_sram_wdata, a_sram_rdata;
  logic        a_ce_n, a_oe_n, a_we_n;
  logic [1:0]  a_be_n;

  // Wide instance
  logic [18:0] b_address;
  logic [7:0]  b_be;
  logic        b_read, b_write;
  logic [63:0] b_wdata, b_rdata;
  logic        b_wait, b_rvalid;
  logic [17:0] b_sram_addr;
  logic [15:0] b_sram_wdata, b_sram_rdata;
  logic        b_ce_n, b_oe_n, b_we_n;
  logic [1:0]  b_be_n;

  avmm_sram_bridge u_a (
    .clk(clk), .reset_n(reset_n),
    .avs_address(a_address), .avs_byteenable(a_be),
    .avs_read(a_read), .avs_write(a_write), .avs_writedata(a_wdata),
    .avs_waitrequest(a_wait), .avs_readdata(a_rdata), .avs_readdatavalid(a_rvalid),
    .sram_addr(a_sram_addr), .sram_writedata(a_sram_wdata), .sram_readdata(a_sram_rdata),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .sram_be_n(a_be_n)
  );

  avmm_sram_bridge #(.AVS_DW(64), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYCLES(2)) u_b (
    .clk(clk), .reset_n(reset_n),
    .avs_address(b_address), .avs_byteenable(b_be),
    .avs_read(b_read), .avs_write(b_write), .avs_writedata(b_wdata),
    .avs_waitrequest(b_wait), .avs_readdata(b_rdata), .avs_readdatavalid(b_rvalid),
    .sram_addr(b_sram_addr), .sram_writedata(b_sram_wdata), .sram_readdata(b_sram_rdata),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_be_n(b_be_n)
  );

  // SRAM models: byte-lane writes while ce_n/we_n low, data driven only while
  // ce_n/oe_n low.
  logic [15:0] mem_a [64];
  logic [15:0] mem_b [64];

  always @(posedge clk) begin
    if (!a_ce_n && !a_we_n) begin
      for (int i = 0; i < 2; i++)
        if (!a_be_n[i]) mem_a[a_sram_addr[5:0]][i*8 +: 8] <= a_sram_wdata[i*8 +: 8];
    end
    if (!b_ce_n && !b_we_n) begin
      for (int i = 0; i < 2; i++)
        if (!b_be_n[i]) mem_b[b_sram_addr[5:0]][i*8 +: 8] <= b_sram_wdata[i*8 +: 8];
    end
  end

  assign a_sram_rdata = (!a_ce_n && !a_oe_n) ? mem_a[a_sram_addr[5:0]] : 16'h0;
  assign b_sram_rdata = (!b_ce_n && !b_oe_n) ? mem_b[b_sram_addr[5:0]] : 16'h0;

  // Issue one request on the default instance and observe it cycle by cycle.
  // Cycle c is the c-th cycle after the accepting edge.
  task automatic a_op(input bit wr, input logic [18:0] addr, input logic [3:0] be,
                      input logic [31:0] data, output int busy, output int lat,
                      output int nacc, output logic [17:0] first_addr,
                      output logic [1:0] first_be_n, output bit tmo);
    busy = 0; lat = 0; nacc = 0; first_addr = '0; first_be_n = '1; tmo = 1'b1;
    @(negedge clk);
    a_address = addr; a_be = be; a_wdata = data; a_write = wr; a_read = !wr;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin a_write = 1'b0; a_read = 1'b0; end
      if (a_wait) busy++;
      if (!a_ce_n) begin
        if (nacc == 0) begin first_addr = a_sram_addr; first_be_n = a_be_n; end
        nacc++;
      end
      if (a_rvalid && lat == 0) lat = c;
      if (!a_wait && (wr || lat != 0)) begin tmo = 1'b0; break; end
    end
  endtask

  logic [17:0] b_starts [8];
  int          b_nstart;

  task automatic b_op(input bit wr, input logic [18:0] addr, input logic [7:0] be,
                      input logic [63:0] data, output int busy, output int lat,
                      output int nacc, output bit tmo);
    logic prev_ce_n;
    busy = 0; lat = 0; nacc = 0; tmo = 1'b1; b_nstart = 0; prev_ce_n = 1'b1;
    @(negedge clk);
    b_address = addr; b_be = be; b_wdata = data; b_write = wr; b_read = !wr;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin b_write = 1'b0; b_read = 1'b0; end
      if (b_wait) busy++;
      if (!b_ce_n) begin
        nacc++;
        if (prev_ce_n && b_nstart < 8) begin b_starts[b_nstart] = b_sram_addr; b_nstart++; end
      end
      prev_ce_n = b_ce_n;
      if (b_rvalid && lat == 0) lat = c;
      if (!b_wait && (wr || lat != 0)) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    checks++; if (a_wait !== 1'b0) begin errors++; $display("FAIL rst_wait: got %b want 0", a_wait); end
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", a_rvalid); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", a_rdata); end
    checks++; if ({a_ce_n, a_oe_n, a_we_n} !== 3'b111) begin
      errors++; $display("FAIL rst_strobes: got %b want 111", {a_ce_n, a_oe_n, a_we_n}); end
    checks++; if (a_be_n !== 2'b11) begin errors++; $display("FAIL rst_be_n: got %b want 11", a_be_n); end
    checks++; if (a_sram_addr !== 18'h0 || a_sram_wdata !== 16'h0) begin
      errors++; $display("FAIL rst_addr_data: got %h/%h want 0/0", a_sram_addr, a_sram_wdata); end
  endtask

  task automatic test_full_write_read;
    int busy, lat, nacc; logic [17:0] fa; logic [1:0] fb; bit tmo;
    a_op(1'b1, 19'h0, 4'hf, 32'hcccc0123, busy, lat, nacc, fa, fb, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL fw_timeout: got timeout want completion"); end
    checks++; if (busy !== 3) begin errors++; $display("FAIL fw_busy: got %0d want 3", busy); end
    checks++; if (nacc !== 2) begin errors++; $display("FAIL fw_access: got %0d want 2", nacc); end
    checks++; if (mem_a[0] !== 16'h0123 || mem_a[1] !== 16'hcccc) begin
      errors++; $display("FAIL fw_mem: got %h %h want 0123 cccc", mem_a[0], mem_a[1]); end
    a_op(1'b0, 19'h0, 4'h0, 32'h0, busy, lat, nacc, fa, fb, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL fr_timeout: got timeout want completion"); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL fr_latency: got %0d want 4", lat); end
    checks++; if (busy !== 3) begin errors++; $display("FAIL fr_busy: got %0d want 3", busy); end
    checks++; if (a_rdata !== 32'hcccc0123) begin
      errors++; $display("FAIL fr_data: got %h want cccc0123", a_rdata); end
  endtask

  task automatic test_partial_write;
    int busy, lat, nacc; logic [17:0] fa; logic [1:0] fb; bit tmo;
    a_op(1'b1, 19'h20, 4'hf, 32'hdeadbeef, busy, lat, nacc, fa, fb, tmo);
    a_op(1'b1, 19'h20, 4'b0011, 32'h0000ffff, busy, lat, nacc, fa, fb, tmo);
    checks++; if (nacc !== 1 || busy !== 1) begin
      errors++; $display("FAIL pw_single: got access=%0d busy=%0d want 1/1", nacc, busy); end
    checks++; if (fa !== 18'h10 || fb !== 2'b00) begin
      errors++; $display("FAIL pw_addr_be: got %h/%b want 10/00", fa, fb); end
    a_op(1'b0, 19'h20, 4'h0, 32'h0, busy, lat, nacc, fa, fb, tmo);
    checks++; if (a_rdata !== 32'hdeadffff || lat !== 4) begin
      errors++; $display("FAIL pw_read: got %h lat %0d want deadffff lat 4", a_rdata, lat); end
  endtask

  task automatic test_upper_byte;
    int busy, lat, nacc; logic [17:0] fa; logic [1:0] fb; bit tmo;
    a_op(1'b1, 19'h10, 4'hf, 32'h12345678, busy, lat, nacc, fa, fb, tmo);
    a_op(1'b1, 19'h10, 4'b1000, 32'hff345678, busy, lat, nacc, fa, fb, tmo);
    checks++; if (nacc !== 1 || busy !== 1) begin
      errors++; $display("FAIL ub_single: got access=%0d busy=%0d want 1/1", nacc, busy); end
    checks++; if (fa !== 18'h9 || fb !== 2'b01) begin
      errors++; $display("FAIL ub_addr_be: got %h/%b want 9/01", fa, fb); end
    a_op(1'b0, 19'h10, 4'b0011, 32'h0, busy, lat, nacc, fa, fb, tmo);
    checks++; if (a_rdata !== 32'hff345678) begin
      errors++; $display("FAIL ub_read: got %h want ff345678", a_rdata); end
  endtask

  task automatic test_zero_be;
    int busy, lat, nacc; logic [17:0] fa; logic [1:0] fb; bit tmo;
    a_op(1'b1, 19'h0, 4'b0000, 32'hffffffff, busy, lat, nacc, fa, fb, tmo);
    checks++; if (busy !== 0) begin errors++; $display("FAIL zb_wait: got %0d busy want 0", busy); end
    checks++; if (nacc !== 0) begin errors++; $display("FAIL zb_ce: got %0d access want 0", nacc); end
    checks++; if (mem_a[0] !== 16'h0123 || mem_a[1] !== 16'hcccc) begin
      errors++; $display("FAIL zb_mem: got %h %h want 0123 cccc", mem_a[0], mem_a[1]); end
  endtask

  // Read held high: the second read is accepted in the readdatavalid cycle.
  task automatic test_back_to_back;
    int rv_cnt, rv_first, rv_second;
    logic [31:0] d2;
    rv_cnt = 0; rv_first = 0; rv_second = 0; d2 = '0;
    @(negedge clk);
    a_address = 19'h20; a_read = 1'b1; a_write = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) a_read = 1'b0;
      if (a_rvalid) begin
        rv_cnt++;
        if (rv_cnt == 1) rv_first = c;
        if (rv_cnt == 2) begin rv_second = c; d2 = a_rdata; end
      end
    end
    checks++; if (rv_cnt !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", rv_cnt); end
    checks++; if (rv_first !== 4 || rv_second !== 8) begin
      errors++; $display("FAIL b2b_cycles: got %0d,%0d want 4,8", rv_first, rv_second); end
    checks++; if (d2 !== 32'hdeadffff) begin errors++; $display("FAIL b2b_data: got %h want deadffff", d2); end
  endtask

  task automatic test_reset_mid;
    int busy, lat, nacc, rv_seen; logic [17:0] fa; logic [1:0] fb; bit tmo;
    @(negedge clk);
    a_address = 19'h20; a_read = 1'b1;
    @(negedge clk); a_read = 1'b0;   // cycle 1: first beat
    @(negedge clk);                  // cycle 2: turnaround
    @(negedge clk);                  // cycle 3: second beat
    checks++; if (a_ce_n !== 1'b0 || a_sram_addr !== 18'h11) begin
      errors++; $display("FAIL rm_beat2: got ce_n=%b addr=%h want 0/11", a_ce_n, a_sram_addr); end
    reset_n = 1'b0;
    #1;
    checks++; if (a_wait !== 1'b0 || a_rvalid !== 1'b0 || a_rdata !== 32'h0) begin
      errors++; $display("FAIL rm_avs: got wait=%b rv=%b data=%h want 0/0/0", a_wait, a_rvalid, a_rdata); end
    checks++; if ({a_ce_n, a_oe_n, a_we_n} !== 3'b111 || a_sram_addr !== 18'h0 || a_be_n !== 2'b11) begin
      errors++; $display("FAIL rm_sram: got %b addr=%h be_n=%b want 111/0/11",
                         {a_ce_n, a_oe_n, a_we_n}, a_sram_addr, a_be_n); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rv_seen = 0;
    repeat (6) begin @(negedge clk); if (a_rvalid) rv_seen++; end
    checks++; if (rv_seen !== 0) begin errors++; $display("FAIL rm_no_rvalid: got %0d pulses want 0", rv_seen); end
    a_op(1'b0, 19'h0, 4'h0, 32'h0, busy, lat, nacc, fa, fb, tmo);
    checks++; if (a_rdata !== 32'hcccc0123 || lat !== 4) begin
      errors++; $display("FAIL rm_reread: got %h lat %0d want cccc0123 lat 4", a_rdata, lat); end
  endtask

  task automatic test_wide;
    int busy, lat, nacc; bit tmo;
    b_op(1'b1, 19'h8, 8'hff, 64'h0123456789abcdef, busy, lat, nacc, tmo);
    checks++; if (tmo || busy !== 15 || nacc !== 12) begin
      errors++; $display("FAIL wide_write_timing: got tmo=%0d busy=%0d access=%0d want 0/15/12",
                         tmo, busy, nacc); end
    checks++; if (b_nstart !== 4 || b_starts[0] !== 18'h4 || b_starts[1] !== 18'h5 ||
                  b_starts[2] !== 18'h6 || b_starts[3] !== 18'h7) begin
      errors++; $display("FAIL wide_addrs: got n=%0d %h %h %h %h want 4 4 5 6 7", b_nstart,
                         b_starts[0], b_starts[1], b_starts[2], b_starts[3]); end
    checks++; if (mem_b[4] !== 16'hcdef || mem_b[5] !== 16'h89ab || mem_b[6] !== 16'h4567 ||
                  mem_b[7] !== 16'h0123) begin
      errors++; $display("FAIL wide_mem: got %h %h %h %h want cdef 89ab 4567 0123",
                         mem_b[4], mem_b[5], mem_b[6], mem_b[7]); end
    b_op(1'b0, 19'h8, 8'h0, 64'h0, busy, lat, nacc, tmo);
    checks++; if (tmo || lat !== 16) begin
      errors++; $display("FAIL wide_latency: got tmo=%0d lat=%0d want 0/16", tmo, lat); end
    checks++; if (b_rdata !== 64'h0123456789abcdef) begin
      errors++; $display("FAIL wide_data: got %h want 0123456789abcdef", b_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    reset_n = 1'b0;
    a_address = '0; a_be = '0; a_read = 1'b0; a_write = 1'b0; a_wdata = '0;
    b_address = '0; b_be = '0; b_read = 1'b0; b_write = 1'b0; b_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_full_write_read;
    test_partial_write;
    test_upper_byte;
    test_zero_be;
    test_back_to_back;
    test_reset_mid;
    test_wide;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
